// File: rtl/alu_pkg.sv
// Shared ALU issue definitions: opcodes, sequencer states, counter width.
// Used by the issue sequencer, its decoder and the control unit.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_SHR = 5'b00101;
  localparam logic [4:0] OP_SHL = 5'b00110;
  localparam logic [4:0] OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000;
  localparam logic [4:0] OP_AND = 5'b01001;
  localparam logic [4:0] OP_OR  = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_NEG = 5'b10000;
  localparam logic [4:0] OP_NOT = 5'b10001;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_Y,
    S_EXEC,
    S_CAPTURE,
    S_RESP
  } state_e;

endpackage

// File: rtl/alu_issue_seq_if.sv
// Request, response and ALU strobe bundle of the issue sequencer.
// master = control unit / ALU side, slave = sequencer.
interface alu_issue_seq_if;

  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic [31:0] alu_op;
  logic [31:0] alu_y;
  logic [31:0] alu_bus;
  logic [31:0] alu_zlow;
  logic [31:0] alu_zhigh;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic        rsp_hilo;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b,
    output rsp_ready, alu_zlow, alu_zhigh,
    input  req_ready, alu_op, alu_y, alu_bus,
    input  rsp_valid, rsp_lo, rsp_hi,
    input  rsp_hilo, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  rsp_ready, alu_zlow, alu_zhigh,
    output req_ready, alu_op, alu_y, alu_bus,
    output rsp_valid, rsp_lo, rsp_hi,
    output rsp_hilo, rsp_err
  );

endinterface

// File: rtl/alu_issue_decode.sv
// Opcode classifier: legal, long-latency and HI/LO-target flags.
// Purely combinational; shared with the control unit.
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [4:0] op,
  output logic       legal,
  output logic       long_op,
  output logic       hilo
);

  always_comb begin
    legal   = 1'b0;
    long_op = 1'b0;
    hilo    = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR,
      OP_NEG, OP_NOT: legal = 1'b1;
      OP_MUL, OP_DIV: begin
        legal   = 1'b1;
        long_op = 1'b1;
        hilo    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_seq.sv
// Multi-cycle ALU issue sequencer: load Y, drive bus/op, settle, capture Z.
// Define ALU_ISSUE_DIVZERO_CHK_EN to short-circuit div-by-zero as an error.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int unsigned SHORT_SETTLE = 1,
  parameter int unsigned LONG_SETTLE  = 4
) (
  input  logic            clk,
  input  logic            clr,
  alu_issue_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] SHORT_CNT = CNT_W'(SHORT_SETTLE);
  localparam logic [CNT_W-1:0] LONG_CNT  = CNT_W'(LONG_SETTLE);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_q, hi_d;
  logic             hilo_q, hilo_d;
  logic             err_q, err_d;

  logic dec_legal;
  logic dec_long;
  logic dec_hilo;
  logic div_zero;
  logic accept;

  alu_issue_decode u_dec (
    .op      (bus.req_op),
    .legal   (dec_legal),
    .long_op (dec_long),
    .hilo    (dec_hilo)
  );

`ifdef ALU_ISSUE_DIVZERO_CHK_EN
  assign div_zero = (bus.req_op == OP_DIV)
                 && (bus.req_b == 32'd0);
`else
  assign div_zero = 1'b0;
`endif

  assign bus.req_ready = (state_q == S_IDLE) && !clr;
  assign accept = bus.req_valid && bus.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    hilo_d  = hilo_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = bus.req_op;
          a_d    = bus.req_a;
          b_d    = bus.req_b;
          lo_d   = '0;
          hi_d   = '0;
          hilo_d = dec_hilo;
          err_d  = 1'b0;
          if (!dec_legal || div_zero) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = dec_long ? LONG_CNT : SHORT_CNT;
            state_d = S_LOAD_Y;
          end
        end
      end
      S_LOAD_Y: state_d = S_EXEC;
      S_EXEC: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CAPTURE: begin
        lo_d    = bus.alu_zlow;
        // divide leaves the ALU high word undefined
        hi_d    = (op_q == OP_DIV) ? '0 : bus.alu_zhigh;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      hilo_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      hilo_q  <= hilo_d;
      err_q   <= err_d;
    end
  end

  assign bus.alu_op  = (state_q == S_EXEC)
                     ? {op_q, 27'd0} : '0;
  assign bus.alu_y   = (state_q == S_LOAD_Y
                     || state_q == S_EXEC) ? a_q : '0;
  assign bus.alu_bus = (state_q == S_EXEC) ? b_q : '0;

  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_lo    = lo_q;
  assign bus.rsp_hi    = hi_q;
  assign bus.rsp_hilo  = hilo_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: registered ALU model, directed and random ops.
// Expected responses come from an opcode-rule reference model.
module tb_alu_issue_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic clr;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_seq_if bus ();

  alu_issue_seq #(
    .SHORT_SETTLE (1),
    .LONG_SETTLE  (4)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  function automatic logic [63:0] alu_f(
    input logic [4:0]  op,
    input logic [31:0] y,
    input logic [31:0] b
  );
    logic [31:0]        lo;
    logic [63:0]        yy;
    logic signed [31:0] sy, sb;
    logic signed [63:0] sy64, sb64, p;
    sy = y;
    sb = b;
    lo = '0;
    case (op)
      OP_ADD: lo = y + b;
      OP_SUB: lo = y - b;
      OP_SHR: lo = y >> b[4:0];
      OP_SHL: lo = y << b[4:0];
      OP_ROR: begin
        yy = {y, y} >> b[4:0];
        lo = yy[31:0];
      end
      OP_ROL: begin
        yy = {y, y} << b[4:0];
        lo = yy[63:32];
      end
      OP_AND: lo = y & b;
      OP_OR:  lo = y | b;
      OP_MUL: begin
        sy64 = sy;
        sb64 = sb;
        p = sy64 * sb64;
        return p;
      end
      OP_DIV: begin
        if (b == 32'd0)
          return {y, 32'hFFFF_FFFF};
        if (y == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'd0, y};
        return {32'(sy % sb), 32'(sy / sb)};
      end
      OP_NEG: lo = -b;
      OP_NOT: lo = ~b;
      default: lo = '0;
    endcase
    return {{32{lo[31]}}, lo};
  endfunction

  // Registered Z outputs, as on the datapath
  always @(posedge clk)
    {bus.alu_zhigh, bus.alu_zlow} <=
      alu_f(bus.alu_op[31:27], bus.alu_y, bus.alu_bus);

  task automatic model(
    input  logic [4:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output int          settle,
    output logic [31:0] lo,
    output logic [31:0] hi,
    output logic        hilo,
    output logic        err
  );
    logic        legal, lng, dz;
    logic [63:0] r;
    legal = op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL,
                       OP_ROR, OP_ROL, OP_AND, OP_OR,
                       OP_MUL, OP_DIV, OP_NEG, OP_NOT};
    lng = op inside {OP_MUL, OP_DIV};
    dz  = 1'b0;
`ifdef ALU_ISSUE_DIVZERO_CHK_EN
    dz = (op == OP_DIV) && (b == 32'd0);
`endif
    if (!legal || dz) begin
      lat = 1; settle = 0;
      lo = '0; hi = '0; hilo = dz; err = 1'b1;
    end else begin
      settle = lng ? 4 : 1;
      lat = settle + 3;
      r = alu_f(op, a, b);
      lo = r[31:0];
      hi = (op == OP_DIV) ? 32'd0 : r[63:32];
      hilo = lng;
      err = 1'b0;
    end
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic run_op(
    input logic [4:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          bp
  );
    int          lat, settle, n, w;
    logic [31:0] elo, ehi;
    logic        ehilo, eerr;
    model(op, a, b, lat, settle, elo, ehi, ehilo, eerr);
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op = 5'($urandom);
    bus.req_a = $urandom;
    bus.req_b = $urandom;
    n = 1;
    while (1) begin
      chk("alu_y", bus.alu_y,
          (settle > 0 && n <= settle + 1) ? a : 32'd0);
      chk("alu_bus", bus.alu_bus,
          (settle > 0 && n >= 2 && n <= settle + 1)
            ? b : 32'd0);
      chk("alu_op", bus.alu_op,
          (settle > 0 && n >= 2 && n <= settle + 1)
            ? {op, 27'd0} : 32'd0);
      chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
      if (bus.rsp_valid || n >= 40) break;
      bus.rsp_ready = 1'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    bus.rsp_ready = (bp == 0);
    for (int i = 0; i <= bp; i++) begin
      chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("rsp_lo", bus.rsp_lo, elo);
      chk("rsp_hi", bus.rsp_hi, ehi);
      chk("rsp_hilo", 64'(bus.rsp_hilo), 64'(ehilo));
      chk("rsp_err", 64'(bus.rsp_err), 64'(eerr));
      if (i > 0)
        chk("req_ready_bp", 64'(bus.req_ready), 64'd0);
      if (i == bp) bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b0;
    chk("rsp_done", 64'(bus.rsp_valid), 64'd0);
    chk("ready_after", 64'(bus.req_ready), 64'd1);
  endtask

  logic [4:0] legal_ops [12] = '{
    OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
    OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT
  };

  initial begin
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    clr = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_lo", bus.rsp_lo, 32'd0);
    chk("rst_rsp_hi", bus.rsp_hi, 32'd0);
    chk("rst_rsp_hilo", 64'(bus.rsp_hilo), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_alu_op", bus.alu_op, 32'd0);
    chk("rst_alu_y", bus.alu_y, 32'd0);
    chk("rst_alu_bus", bus.alu_bus, 32'd0);
    clr = 1'b0;
    #1;
    chk("rst_release_ready", 64'(bus.req_ready), 64'd1);

    run_op(OP_ADD, 32'd5, 32'd3, 0);
    run_op(OP_MUL, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(5'b11111, 32'h1234, 32'h5678, 1);
    run_op(OP_SUB, 32'd10, 32'd3, 5);
    run_op(OP_DIV, 32'd7, 32'd0, 0);
    run_op(OP_DIV, 32'd100, 32'd7, 2);

    // clr during EXEC of a div drops the op
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = OP_DIV;
    bus.req_a = 32'd50;
    bus.req_b = 32'd5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("clr_in_exec", bus.alu_op, {OP_DIV, 27'd0});
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_req_ready", 64'(bus.req_ready), 64'd0);
    chk("clr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("clr_alu_op", bus.alu_op, 32'd0);
    chk("clr_alu_y", bus.alu_y, 32'd0);
    chk("clr_rsp_hilo", 64'(bus.rsp_hilo), 64'd0);
    clr = 1'b0;
    #1;
    chk("clr_ready_back", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("clr_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    run_op(OP_ADD, 32'd20, 32'd22, 0);

    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 3) == 0)
        rop = 5'($urandom);
      else
        rop = legal_ops[$urandom_range(0, 11)];
      ra = $urandom;
      rb = $urandom;
      if (rop == OP_DIV && $urandom_range(0, 2) == 0)
        rb = 32'd0;
      run_op(rop, ra, rb, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Multi-cycle issue sequencer that drives the datapath ALU. It accepts an operation request over a valid/ready handshake and loads operand A into the ALU Y input. It then presents operand B on the bus input, waits an opcode-dependent settle time, and captures the ALU Zlow/Zhigh results. The captured result is returned over a second valid/ready handshake. It is the initiator for the ALU: the control unit issues work here instead of hand-sequencing Y/bus/Z strobes.

## Interface
Parameters:
- SHORT_SETTLE, 1: EXEC cycles for single-cycle ops; legal range 1..15.
- LONG_SETTLE, 4: EXEC cycles for mul/div; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- clr  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept.
- req_op  in  5  ALU opcode.
- req_a  in  32  operand A, sent to ALU Y input.
- req_b  in  32  operand B, sent to ALU bus input.
- alu_op  out  32  ALU operator word: opcode in [31:27], [26:0]=0.
- alu_y  out  32  ALU Y operand.
- alu_bus  out  32  ALU bus operand.
- alu_zlow  in  32  ALU low result.
- alu_zhigh  in  32  ALU high result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_lo  out  32  captured low word.
- rsp_hi  out  32  captured high word.
- rsp_hilo  out  1  response targets HI/LO (mul/div).
- rsp_err  out  1  illegal opcode, or divide-by-zero when enabled.

## Operation
- Legal opcodes: add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, mul 01110, div 01111, neg 10000, not 10001. Every other opcode is illegal.
- Long ops are mul and div; they use LONG_SETTLE. All other legal ops use SHORT_SETTLE.
- States and transitions:
  - IDLE: req_ready=1. On accept, go to LOAD_Y.
  - LOAD_Y: drive alu_y=A. Go to EXEC.
  - EXEC: drive alu_y=A, alu_bus=B, alu_op. Count down the settle count. At count end, go to CAPTURE.
  - CAPTURE: register alu_zlow and alu_zhigh. Go to RESP.
  - RESP: rsp_valid=1. On handshake, go to IDLE.
- Illegal opcode: go from IDLE straight to RESP. Response is rsp_err=1, rsp_lo=0, rsp_hi=0, rsp_hilo=0. The ALU is not driven.
- rsp_hi values:
  - Mul: rsp_hi = alu_zhigh.
  - Div: rsp_hi is forced to 0, because the ALU high word is undefined for divide.
  - Other ops: rsp_hi = alu_zhigh (sign extension of the low word).
- rsp_hilo=1 for mul and div only.
- Request operands and opcode are registered at accept. Later changes to req_* do not affect an op in flight.
- Outside LOAD_Y/EXEC, alu_op, alu_y and alu_bus are 0.

## Timing
- Reset values: req_ready=0 while clr=1 (1 in the first IDLE cycle after). rsp_valid=0, rsp_lo=0, rsp_hi=0, rsp_hilo=0, rsp_err=0, alu_op=0, alu_y=0, alu_bus=0. State is IDLE.
- Accept on the edge where req_valid & req_ready. rsp_valid rises S+3 edges after accept, where S is the settle count:
  - Short op: 4 cycles.
  - Long op with default LONG_SETTLE: 7 cycles.
  - Illegal op: rsp_valid rises 1 edge after accept.
- rsp_* hold stable while rsp_valid=1 and rsp_ready=0.
- req_ready is low from accept until the cycle after the response handshake. There is no same-cycle response-then-accept; minimum issue interval is S+4 cycles.
- rsp_ready asserted before rsp_valid has no effect.
- clr mid-operation: next edge returns to IDLE with all outputs at reset values. The in-flight op is dropped and no response is issued.

## Configuration
- ALU_ISSUE_DIVZERO_CHK_EN defined:
  - Div with B=0 is treated like an illegal op: 1-cycle path to RESP, rsp_err=1, rsp_lo=0, rsp_hi=0, rsp_hilo=1.
  - The ALU is not driven.
- ALU_ISSUE_DIVZERO_CHK_EN not defined:
  - Div with B=0 executes normally; rsp_lo = alu_zlow as returned, rsp_hi=0, rsp_err=0.

## Structure
- Shared package alu_pkg holds:
  - 5-bit opcode constants.
  - State enum: IDLE, LOAD_Y, EXEC, CAPTURE, RESP.
  - Settle-counter width (4 bits).
- One sub-module, alu_issue_decode: combinational map from opcode to legal, long, and hilo flags. It is reused by the control unit.

## Test plan
- Add: op=00011, A=0x0000_0005, B=0x0000_0003 -> rsp_valid 4 cycles after accept; rsp_lo=0x8, rsp_hi=0, rsp_hilo=0, rsp_err=0.
- Mul: op=01110, A=0xFFFF_FFFF, B=0x2 -> rsp_valid 7 cycles after accept; rsp_lo=0xFFFF_FFFE, rsp_hi=0xFFFF_FFFF, rsp_hilo=1.
- Illegal op 11111 -> rsp_valid 1 cycle after accept; rsp_err=1, rsp_lo=0, rsp_hi=0; alu_op stays 0 throughout.
- Back-pressure: hold rsp_ready=0 for 5 cycles on a sub, 10-3 -> rsp_lo=7 stable throughout; req_ready=0 throughout; after handshake, req_ready=1 on the next cycle.
- clr asserted during EXEC of a div -> IDLE next edge, no rsp_valid; a following add completes normally.
- Div 7/0: with ALU_ISSUE_DIVZERO_CHK_EN -> rsp_err=1 after 1 cycle; without it -> rsp_err=0, response after 7 cycles.
